// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// APB_PREADY_EN adds the PREADY input from the slave.
interface apb_master_bridge_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
  logic [AMBA_WORD-1:0]       cmd_wdata;
  logic                       rsp_valid;
  logic                       rsp_write;
  logic [AMBA_WORD-1:0]       rsp_rdata;
  logic                       rsp_err;
  logic                       busy;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
`ifdef APB_PREADY_EN
  logic                       PREADY;
`endif

  modport master (
`ifdef APB_PREADY_EN
    input  PREADY,
`endif
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA,
    output cmd_ready, busy,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
`ifdef APB_PREADY_EN
    output PREADY,
`endif
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA,
    input  cmd_ready, busy,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: command FIFO feeding an IDLE/SETUP/ACCESS transfer FSM.
// APB_PREADY_EN: ACCESS ends on PREADY or timeout instead of a fixed length.
module apb_master_bridge #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int CMD_DEPTH       = 4,
  parameter int ACCESS_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input logic                 clk,
  input logic                 rst,
  apb_master_bridge_if.master bus
);
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_MAX = (ACCESS_CYCLES > TIMEOUT_CYCLES)
                         ? ACCESS_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam int EW = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;
`ifdef APB_PREADY_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CW-1:0] ACC_LAST = CW'(ACCESS_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  logic [EW-1:0] r_mem [CMD_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_head;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_cnt;
  logic                       w_done;
  logic                       w_tmo;
  logic                       r_psel;
  logic                       r_penable;
  logic                       r_pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;
  logic                       r_rsp_valid;
  logic                       r_rsp_write;
  logic [AMBA_WORD-1:0]       r_rsp_rdata;
  logic                       r_rsp_err;

  assign w_full  = (r_count == (PW+1)'(CMD_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
`ifdef APB_PREADY_EN
        if (bus.PREADY) begin
          w_done = 1'b1;
        end else if (r_cnt == TMO_LAST) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
`else
        if (r_cnt == ACC_LAST) w_done = 1'b1;
`endif
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs follow the next state so they are registered yet aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= (w_state_nxt != S_IDLE);
      r_penable   <= (w_state_nxt == S_ACCESS);
      r_rsp_valid <= w_done;
      if (w_pop) begin
        {r_pwrite, r_paddr, r_pwdata} <= w_head;
        r_cnt <= '0;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_done) begin
        r_rsp_write <= r_pwrite;
        r_rsp_rdata <= (r_pwrite || w_tmo) ? '0 : bus.PRDATA;
        r_rsp_err   <= w_tmo;
      end
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.busy      = !w_empty || (r_state != S_IDLE);
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: small APB register slave, timing/ordering
// model of expected responses, and directed literal checks.
module tb_apb_master_bridge;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef APB_PREADY_EN
  localparam int ACC_OK = 2;
`else
  localparam int ACC_OK = 3;
`endif
  localparam int ACC_TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_master_bridge_if #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW)) bus ();

  apb_master_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // APB register slave: four words at 0x0/0x4/0x8/0xC, others read 0
  logic [DW-1:0] sregs [4];
  int   acc_n = 0;
  logic w_hit;
  logic w_rdy;
  assign w_hit = (bus.PADDR[AW-1:4] == '0) && (bus.PADDR[1:0] == 2'b00);
  always_comb bus.PRDATA = w_hit ? sregs[bus.PADDR[3:2]] : '0;
`ifdef APB_PREADY_EN
  logic stall = 1'b0;
  assign w_rdy = bus.PENABLE && (acc_n == 1) && !stall;
  assign bus.PREADY = w_rdy;
`else
  assign w_rdy = 1'b1;
`endif
  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE) acc_n <= acc_n + 1;
    else acc_n <= 0;
    if (bus.PSEL && bus.PENABLE && bus.PWRITE && w_rdy && w_hit)
      sregs[bus.PADDR[3:2]] <= bus.PWDATA;
  end

  // Model: each accepted command gets its SETUP and response cycle numbers
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] d;
    logic          e;
    int            ts;
    int            tr;
  } exp_t;

  exp_t q[$];
  logic [DW-1:0] mregs [4];
  int cyc = 0;
  int last_t = 0;
  int last_acc = 0;
  int n_acc = 0;
  int n_rsp = 0;
  int first_block = -1;
  logic [DW-1:0] last_rdata = '0;
  logic last_rwrite = 1'b0;
  logic last_err = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) begin
      sregs[i] = '0;
      mregs[i] = '0;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      q.delete();
      last_t = 0;
    end else if (bus.cmd_valid && bus.cmd_ready) begin : acc_blk
      exp_t e;
      int acc;
      int base;
      logic hit;
      e.w  = bus.cmd_write;
      e.a  = bus.cmd_addr;
      e.wd = bus.cmd_wdata;
`ifdef APB_PREADY_EN
      e.e  = stall;
`else
      e.e  = 1'b0;
`endif
      acc = e.e ? ACC_TMO : ACC_OK;
      hit = (e.a[AW-1:4] == '0) && (e.a[1:0] == 2'b00);
      if (e.w) begin
        e.d = '0;
        if (hit && !e.e) mregs[e.a[3:2]] = e.wd;
      end else begin
        e.d = (hit && !e.e) ? mregs[e.a[3:2]] : '0;
      end
      base = (cyc > last_t) ? cyc : last_t;
      e.ts = base + 1;
      e.tr = base + 2 + acc;
      last_t = e.tr;
      q.push_back(e);
      last_acc = cyc;
      n_acc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_psel", bus.PSEL, 0);
      chk("rst_penable", bus.PENABLE, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
    end else begin : cmp
      logic ev;
      logic ep;
      logic en;
      int pend;
      ev = (q.size() > 0) && (q[0].tr == cyc);
      chk("rsp_valid", bus.rsp_valid, ev);
      if (bus.rsp_valid) begin
        n_rsp++;
        last_rdata  = bus.rsp_rdata;
        last_rwrite = bus.rsp_write;
        last_err    = bus.rsp_err;
      end
      if (ev) begin
        if (bus.rsp_valid) begin
          chk("rsp_write", bus.rsp_write, q[0].w);
          chk("rsp_rdata", bus.rsp_rdata, q[0].d);
          chk("rsp_err", bus.rsp_err, q[0].e);
        end
        void'(q.pop_front());
      end
      ep = (q.size() > 0) && (cyc >= q[0].ts) && (cyc < q[0].tr);
      en = ep && (cyc > q[0].ts);
      chk("psel", bus.PSEL, ep);
      chk("penable", bus.PENABLE, en);
      if (ep) begin
        chk("paddr", bus.PADDR, q[0].a);
        chk("pwrite", bus.PWRITE, q[0].w);
        if (q[0].w) chk("pwdata", bus.PWDATA, q[0].wd);
      end
      chk("busy", bus.busy, q.size() > 0);
      pend = 0;
      foreach (q[i]) if (q[i].ts > cyc) pend++;
      chk("cmd_ready", bus.cmd_ready, pend < DEPTH);
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      if (first_block < 0) first_block = n_acc;
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: cmd_ready stuck at %0b required 1",
               bus.cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: busy=%0b pending=%0d required 0",
               bus.busy, q.size());
    end
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } vec_t;

  vec_t vecs [6];
  int n0;
  int r0;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    vecs[0] = '{1'b1, 20'h0, 32'h0000_0011};
    vecs[1] = '{1'b1, 20'h4, 32'h2222_2222};
    vecs[2] = '{1'b1, 20'h8, 32'h0000_0033};
    vecs[3] = '{1'b1, 20'hC, 32'h4444_4444};
    vecs[4] = '{1'b0, 20'h4, 32'h0};
    vecs[5] = '{1'b0, 20'hC, 32'h0};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_psel", bus.PSEL, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_cmd_ready", bus.cmd_ready, 1);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send(1'b1, 20'h4, 32'hDEAD_BEEF);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_psel", bus.PSEL, 1);
    chk("t1_penable", bus.PENABLE, 0);
    @(negedge clk);
    chk("t2_penable", bus.PENABLE, 1);
    repeat (ACC_OK - 1) @(negedge clk);
    chk("tlast_penable", bus.PENABLE, 1);
    @(negedge clk);
    chk("tresp_valid", bus.rsp_valid, 1);
    chk("tresp_write", bus.rsp_write, 1);
    chk("tresp_psel", bus.PSEL, 0);
    chk("slave_data_in", sregs[1], 32'hDEAD_BEEF);
    wait_idle();

    send(1'b0, 20'h4, 32'h0);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("rd4_data", last_rdata, 32'hDEAD_BEEF);
    chk("rd4_write", last_rwrite, 0);
    chk("rd4_err", last_err, 0);

    send(1'b0, 20'h10, 32'h0);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("rd10_data", last_rdata, 0);

    first_block = -1;
    n0 = n_acc;
    r0 = n_rsp;
    for (int i = 0; i < 6; i++) send(vecs[i].w, vecs[i].a, vecs[i].d);
    bus.cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_full_at", first_block - n0, 5);
    chk("b2b_rsp_count", n_rsp - r0, 6);
    chk("b2b_last_rd", last_rdata, 32'h4444_4444);
    chk("b2b_slave_ctrl", sregs[0], 32'h0000_0011);

    r0 = n_rsp;
    send(1'b0, 20'h8, 32'h0);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_psel", bus.PSEL, 0);
    chk("abort_penable", bus.PENABLE, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_rsp", n_rsp - r0, 0);

`ifdef APB_PREADY_EN
    stall = 1'b1;
    send(1'b0, 20'h4, 32'h0);
    bus.cmd_valid = 1'b0;
    wait_idle();
    stall = 1'b0;
    chk("tmo_err", last_err, 1);
    chk("tmo_rdata", last_rdata, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
